dmem_sized: RTL and testbench
=============================

Name: dmem_sized

Overview:
Parametrised data memory for the MEM stage of the pipelined core. It supports byte, halfword and word loads and stores, with per-lane byte enables and sign or zero extension on loads. Access latency is configurable, and a stall output holds the pipeline while an access is in flight. Misaligned or illegal accesses are flagged and suppressed, so they never corrupt memory.

Parameters:
DEPTH, 64, number of 32-bit words; power of 2, at least 4.
LATENCY, 1, wait cycles before the access is performed; legal range 0..15.
AW, 32, address width in bits.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
req  input  1  access request from the MEM stage; held high until the completion cycle.
we  input  1  1 = store, 0 = load.
size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
uns  input  1  load extension: 1 = zero-extend, 0 = sign-extend; ignored on stores.
addr  input  AW  byte address.
wd  input  32  store data, right-justified.
rd  output  32  load data, extended; registered.
stall  output  1  pipeline hold request.
done  output  1  completion pulse, one cycle wide.
misalign  output  1  illegal or misaligned request flag.

Behaviour:
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so the memory aliases.
- Legality:
  - byte: always legal.
  - half: addr[0] must be 0.
  - word: addr[1:0] must be 00.
  - size 11: always illegal.
- Internal registers: state (IDLE, BUSY), 4-bit down-counter cnt, and latched we, size, uns, addr, wd.
- Reset values: state IDLE, cnt 0, rd 0, done 0, latched fields 0. The RAM array is not reset.
- Accept condition, evaluated in IDLE: req=1, done=0, request legal.
  - On the next edge: latch the request, cnt <= LATENCY, state <= BUSY.
  - done=1 marks the completion cycle. In that cycle req is ignored, because the pipeline is still advancing the same instruction.
- BUSY with cnt != 0: cnt decrements; no other change.
- BUSY with cnt == 0: on the edge the access is performed, done <= 1, state <= IDLE.
  - Store, byte: wd[7:0] written to lane addr[1:0]; other lanes untouched.
  - Store, half: wd[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - Store, word: all four lanes written.
  - Load: selected byte or half extracted from the word, extended per uns, and registered into rd.
  - Load, word: full word registered into rd.
- rd holds its value until the next completed load. Stores do not modify rd.
- done is high for exactly one cycle after each completed access, then returns to 0.
- stall (combinational) = (IDLE & req & ~done & legal) | BUSY.
- misalign (combinational) = IDLE & req & ~done & ~legal.
  - No access occurs, state stays IDLE, stall=0.
  - The pipeline handles the trap.
- Timing: a legal access stalls for LATENCY+1 cycles after the request cycle, and rd and done are valid in the cycle where stall drops. Request-to-done = LATENCY+2 cycles.
- Inputs change while BUSY: no effect; the latched copies are used.
- Reset during BUSY: the access is aborted, no RAM write occurs, and done stays 0.
- Back-to-back: a new req is accepted in the cycle after the completion cycle.

Test Plan:
- LATENCY=1: word store 0xDEADBEEF to addr 0x10, then word load 0x10 -> stall high 2 cycles per access; rd=0xDEADBEEF with done=1.
- Byte store 0xAA to 0x12 over word 0x11223344 at 0x10 -> word load returns 0x11AA3344.
- Half load at 0x12 of 0x8001xxxx: uns=0 -> 0xFFFF8001; uns=1 -> 0x00008001. Byte load at 0x13 of 0x80xxxxxx: uns=0 -> 0xFFFFFF80.
- Misaligned requests: word at 0x11, half at 0x13, size=11 -> misalign=1, stall=0, done never rises, subsequent word load shows memory unchanged.
- LATENCY=3: stall high exactly 4 cycles. With req held through the done cycle, no second access occurs; done pulses once.
- Reset asserted mid-BUSY on a store of 0x55 -> state IDLE, done=0, rd=0; a later load shows the old data. DEPTH=64: addr 0x100 aliases to 0x000.

Source files
------------

// File: rtl/dmem_sized_if.sv
// Bus between the MEM stage and the sized data memory.
// The MEM stage is the master. The memory answers with load data,
// a stall request, a completion pulse and a misalignment flag.
interface dmem_sized_if #(
    parameter int AW = 32
);
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic          stall;
    logic          done;
    logic          misalign;

    modport master (
        output req, we, size, uns, addr, wd,
        input  rd, stall, done, misalign
    );

    modport slave (
        input  req, we, size, uns, addr, wd,
        output rd, stall, done, misalign
    );
endinterface

// File: rtl/dmem_sized.sv
// Sized data memory for the MEM stage.
// Handles byte, half and word accesses with a configurable wait latency.
// Illegal or misaligned requests are flagged and never reach the RAM.
module dmem_sized #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1,
    parameter int AW      = 32
) (
    input  logic        clk,
    input  logic        reset,
    dmem_sized_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            l_we;
    logic            l_uns;
    logic [1:0]      l_size;
    logic [IW+1:0]   l_addr;
    logic [31:0]     l_wd;
    logic [31:0]     rd_q;
    logic            done_q;
    logic            legal;
    logic            accept;
    logic            perform;
    logic [IW-1:0]   widx;
    logic [3:0]      be;
    logic [31:0]     wlane;
    logic [31:0]     mem [DEPTH];
    logic            unused_addr_hi;

    // Size/alignment legality of a request.
    function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            2'b10:   return (a == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Pick the addressed byte or half out of a word and extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return u ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'd0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Upper address bits alias onto the array.
    assign unused_addr_hi = ^bus.addr[AW-1:IW+2];

    assign legal        = is_legal(bus.size, bus.addr[1:0]);
    assign widx         = l_addr[IW+1:2];
    assign bus.rd       = rd_q;
    assign bus.done     = done_q;
    assign bus.stall    = ((state == IDLE) && bus.req && !done_q && legal) || (state == BUSY);
    assign bus.misalign = (state == IDLE) && bus.req && !done_q && !legal;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: accept a legal request in IDLE; finish when the wait count runs out.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        perform   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req && !done_q && legal) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    perform   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, wait counter, completion pulse and registered load data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            done_q <= 1'b0;
            rd_q   <= 32'd0;
            l_we   <= 1'b0;
            l_uns  <= 1'b0;
            l_size <= 2'b00;
            l_addr <= '0;
            l_wd   <= 32'd0;
        end else begin
            done_q <= perform;
            if (accept) begin
                l_we   <= bus.we;
                l_uns  <= bus.uns;
                l_size <= bus.size;
                l_addr <= bus.addr[IW+1:0];
                l_wd   <= bus.wd;
                cnt    <= 4'(LATENCY);
            end else if ((state == BUSY) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (perform && !l_we)
                rd_q <= load_ext(mem[widx], l_size, l_addr[1:0], l_uns);
        end
    end

    // Lane enables and replicated store data for the latched request.
    always_comb begin
        be    = 4'b0000;
        wlane = l_wd;
        case (l_size)
            2'b00: begin
                be    = 4'b0001 << l_addr[1:0];
                wlane = {4{l_wd[7:0]}};
            end
            2'b01: begin
                be    = l_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{l_wd[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM write on completion of a store; a reset in the same cycle aborts it.
    always_ff @(posedge clk) begin
        if (!reset && perform && l_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: one instance at LATENCY=1 and one at LATENCY=3.
// The main access table runs on the LATENCY=1 instance.
// The longer-latency instance covers stall length and reset during an access.
module tb_dmem_sized;
    localparam int AW = 32;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req [2];
    logic        we  [2];
    logic        uns [2];
    logic [1:0]  size[2];
    logic [31:0] addr[2];
    logic [31:0] wd  [2];
    logic [31:0] rd  [2];
    logic        stall[2];
    logic        done [2];
    logic        misalign[2];

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          lat[2] = '{1, 3};
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dmem_sized_if #(.AW(AW)) b0();
    dmem_sized_if #(.AW(AW)) b1();

    assign b0.req = req[0];  assign b0.we = we[0];  assign b0.size = size[0];
    assign b0.uns = uns[0];  assign b0.addr = addr[0];  assign b0.wd = wd[0];
    assign rd[0] = b0.rd;  assign stall[0] = b0.stall;
    assign done[0] = b0.done;  assign misalign[0] = b0.misalign;

    assign b1.req = req[1];  assign b1.we = we[1];  assign b1.size = size[1];
    assign b1.uns = uns[1];  assign b1.addr = addr[1];  assign b1.wd = wd[1];
    assign rd[1] = b1.rd;  assign stall[1] = b1.stall;
    assign done[1] = b1.done;  assign misalign[1] = b1.misalign;

    dmem_sized #(.DEPTH(64), .LATENCY(1), .AW(AW)) u_lat1 (.clk(clk), .reset(reset), .bus(b0));
    dmem_sized #(.DEPTH(64), .LATENCY(3), .AW(AW)) u_lat3 (.clk(clk), .reset(reset), .bus(b1));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] data, input logic [31:0] exp_rd, input logic mis);
        vec_t v;
        v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wd = data;
        v.exp_rd = exp_rd; v.exp_mis = mis;
        vecs.push_back(v);
    endtask

    // Legal access: request held until done, inputs scrambled while busy.
    task automatic access(input int d, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] data,
                          input logic [31:0] exp_rd, input bit keep, input string nm);
        int cyc;
        int stl;
        bit got;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; wd[d] = data;
        #1;
        check({nm, ".stall_req"}, {31'd0, stall[d]}, 32'd1);
        check({nm, ".mis"}, {31'd0, misalign[d]}, 32'd0);
        exp_q.push_back(exp_rd);
        cyc = 0; stl = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            addr[d] = $urandom; wd[d] = $urandom; we[d] = ~w; size[d] = 2'($urandom); uns[d] = ~u;
            #1;
            cyc++;
            if (done[d]) got = 1;
            else if (stall[d]) stl++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s.timeout: got no done after %0d cycles expected done", nm, cyc);
            void'(exp_q.pop_front());
            req[d] = 1'b0;
            return;
        end
        check({nm, ".latency"}, cyc, lat[d] + 2);
        check({nm, ".stall_cycles"}, stl, lat[d] + 1);
        check({nm, ".stall_at_done"}, {31'd0, stall[d]}, 32'd0);
        check({nm, ".rd"}, rd[d], exp_q.pop_front());
        if (!keep) begin
            @(negedge clk);
            req[d] = 1'b0;
            #1;
            check({nm, ".single"}, {30'd0, done[d], stall[d]}, 32'd0);
        end
    endtask

    // Illegal access: flagged, never stalls, never completes.
    task automatic bad_access(input int d, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] data, input string nm);
        bit seen;
        @(negedge clk);
        req[d] = 1'b1; we[d] = 1'b1; size[d] = sz; uns[d] = 1'b0; addr[d] = a; wd[d] = data;
        #1;
        check({nm, ".mis"}, {31'd0, misalign[d]}, 32'd1);
        check({nm, ".stall"}, {31'd0, stall[d]}, 32'd0);
        seen = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (done[d] || stall[d] || !misalign[d]) seen = 1;
        end
        check({nm, ".held"}, {31'd0, seen}, 32'd0);
        req[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; uns[d] = 0; size[d] = 0; addr[d] = 0; wd[d] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d.rd", d), rd[d], 32'd0);
            check($sformatf("reset%0d.done", d), {31'd0, done[d]}, 32'd0);
            check($sformatf("reset%0d.stall", d), {31'd0, stall[d]}, 32'd0);
            check($sformatf("reset%0d.mis", d), {31'd0, misalign[d]}, 32'd0);
        end

        //  we size   uns  addr           wd             rd after       misaligned
        add(1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0);
        add(0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
        add(1, 2'b10, 0, 32'h0000_0010, 32'h1122_3344, 32'hDEAD_BEEF, 0);
        add(1, 2'b00, 0, 32'h0000_0012, 32'hFFFF_FFAA, 32'hDEAD_BEEF, 0);
        add(0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'h11AA_3344, 0);
        add(1, 2'b10, 0, 32'h0000_0010, 32'h8001_1234, 32'h11AA_3344, 0);
        add(0, 2'b01, 0, 32'h0000_0012, 32'h0,         32'hFFFF_8001, 0);
        add(0, 2'b01, 1, 32'h0000_0012, 32'h0,         32'h0000_8001, 0);
        add(0, 2'b00, 0, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 0);
        add(0, 2'b00, 1, 32'h0000_0013, 32'h0,         32'h0000_0080, 0);
        add(0, 2'b00, 0, 32'h0000_0011, 32'h0,         32'h0000_0012, 0);
        add(0, 2'b01, 0, 32'h0000_0010, 32'h0,         32'h0000_1234, 0);
        add(1, 2'b01, 0, 32'h0000_0010, 32'h1234_CAFE, 32'h0000_1234, 0);
        add(1, 2'b10, 0, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0,         1);
        add(1, 2'b01, 0, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0,         1);
        add(1, 2'b11, 0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         1);
        add(0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'h8001_CAFE, 0);
        add(1, 2'b10, 0, 32'h0000_0000, 32'h0BAD_F00D, 32'h8001_CAFE, 0);
        add(0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'h0BAD_F00D, 0);
        add(1, 2'b00, 0, 32'h0000_0103, 32'h0000_007F, 32'h0BAD_F00D, 0);
        add(0, 2'b10, 0, 32'h0000_0000, 32'h0,         32'h7FAD_F00D, 0);
        add(0, 2'b01, 0, 32'h0000_0002, 32'h0,         32'h0000_7FAD, 0);
        add(0, 2'b00, 0, 32'h0000_0001, 32'h0,         32'hFFFF_FFF0, 0);
        add(1, 2'b01, 0, 32'h0000_0002, 32'h0000_BEEF, 32'hFFFF_FFF0, 0);
        add(0, 2'b01, 0, 32'h0000_0002, 32'h0,         32'hFFFF_BEEF, 0);
        add(0, 2'b10, 0, 32'hFFFF_0010, 32'h0,         32'h8001_CAFE, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].exp_mis)
                bad_access(0, vecs[i].size, vecs[i].addr, vecs[i].wd, $sformatf("v%0d", i));
            else
                access(0, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                       vecs[i].exp_rd, 1'b0, $sformatf("v%0d", i));
        end

        // Back-to-back: second request accepted in the cycle after done.
        access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8001_CAFE, 1'b1, "b2b_first");
        access(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hBEEF_F00D, 1'b0, "b2b_second");

        // Longer latency instance.
        access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0, "lat3_store");
        access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, "lat3_load");

        // Reset in the middle of a store aborts it.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b10; uns[1] = 1'b0;
        addr[1] = 32'h20; wd[1] = 32'h0000_0055;
        #1;
        check("rst_busy.stall_req", {31'd0, stall[1]}, 32'd1);
        @(negedge clk); #1;
        check("rst_busy.stall_busy", {31'd0, stall[1]}, 32'd1);
        reset = 1'b1;
        req[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy.rd", rd[1], 32'd0);
        check("rst_busy.stall", {31'd0, stall[1]}, 32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (done[1] || stall[1]) seen = 1;
        end
        check("rst_busy.no_done", {31'd0, seen}, 32'd0);
        access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, "rst_busy.old_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
